// File: rtl/inst_queue_pkg.sv
// Shared fetch/decode types: machine word, epoch tags and the instruction-queue entry.
package inst_queue_pkg;

  typedef logic [31:0] rvwordT;

  typedef enum logic [1:0] {
    EPOCH_INVALID = 2'd0,
    EPOCH_RED     = 2'd1,
    EPOCH_BLUE    = 2'd2,
    EPOCH_GREEN   = 2'd3
  } EpochT;

  typedef struct packed {
    rvwordT instr;
    rvwordT pc;
    EpochT  epoch;
  } IqEntryT;

endpackage

// File: rtl/inst_queue.sv
// Instruction queue between fetch and decode: epoch filter, small FIFO, almost-full/overflow flags.
// Optional same-cycle empty-queue bypass with INST_QUEUE_BYPASS_EN.
module inst_queue
  import inst_queue_pkg::*;
#(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned AFULL_SLACK = 2
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   mem_valid,
  input  rvwordT mem_instr,
  input  rvwordT mem_pc,
  input  EpochT  mem_epoch,
  input  EpochT  jump_epoch,
  output logic   dec_valid,
  output rvwordT dec_instr,
  output rvwordT dec_pc,
  output EpochT  dec_epoch,
  input  logic   dec_ready,
  output logic   q_afull,
  output logic   q_overflow
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_TH = CW'(DEPTH - AFULL_SLACK);

  IqEntryT       mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  EpochT         acc_epoch;

  logic    jump;
  logic    empty;
  logic    full;
  logic    enq;
  logic    deq;
  logic    pop;
  logic    push;
  logic    drop;
  IqEntryT head;

  assign jump  = (jump_epoch != EPOCH_INVALID);
  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);
  assign enq   = mem_valid && (mem_epoch == acc_epoch) &&
                 (mem_epoch != EPOCH_INVALID) && !jump;

  always_comb begin
    dec_valid = !empty && !jump;
    head      = mem[rd_ptr];
`ifdef INST_QUEUE_BYPASS_EN
    if (empty && enq) begin
      dec_valid = 1'b1;
      head      = '{instr: mem_instr, pc: mem_pc, epoch: mem_epoch};
    end
`endif
  end

  // Outputs are zeroed when idle so decode never sees stale head storage.
  assign dec_instr = dec_valid ? head.instr : '0;
  assign dec_pc    = dec_valid ? head.pc    : '0;
  assign dec_epoch = dec_valid ? head.epoch : EPOCH_INVALID;

  assign deq  = dec_valid && dec_ready;
  assign pop  = deq && !empty;
  // An empty-queue deq can only be a bypassed response consumed in flight; it is never stored.
  assign push = enq && (!full || pop) && !(empty && deq);
  assign drop = enq && full && !pop;

  assign q_afull = (count >= AFULL_TH);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      acc_epoch  <= EPOCH_RED;
      q_overflow <= 1'b0;
    end else if (jump) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      acc_epoch <= jump_epoch;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
      if (drop) q_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr] <= '{instr: mem_instr, pc: mem_pc, epoch: mem_epoch};
    end
  end

endmodule

// File: tb/tb_inst_queue.sv
// Scoreboard bench for inst_queue: directed scenarios then randomized traffic vs. a queue model.
module tb_inst_queue;
  import inst_queue_pkg::*;

  localparam int DEPTH = 4;
  localparam int SLACK = 2;

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  logic   mem_valid = 1'b0;
  rvwordT mem_instr = '0;
  rvwordT mem_pc = '0;
  EpochT  mem_epoch = EPOCH_INVALID;
  EpochT  jump_epoch = EPOCH_INVALID;
  logic   dec_valid;
  rvwordT dec_instr;
  rvwordT dec_pc;
  EpochT  dec_epoch;
  logic   dec_ready = 1'b0;
  logic   q_afull;
  logic   q_overflow;

  inst_queue #(.DEPTH(DEPTH), .AFULL_SLACK(SLACK)) dut (
    .clk(clk), .rst(rst),
    .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_pc(mem_pc), .mem_epoch(mem_epoch),
    .jump_epoch(jump_epoch),
    .dec_valid(dec_valid), .dec_instr(dec_instr), .dec_pc(dec_pc), .dec_epoch(dec_epoch),
    .dec_ready(dec_ready), .q_afull(q_afull), .q_overflow(q_overflow)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: contents the queue should hold, accepted epoch, sticky loss flag.
  IqEntryT sb[$];
  EpochT   m_acc = EPOCH_RED;
  logic    m_ovf = 1'b0;
  logic    mon_en = 1'b0;
  logic    exp_valid = 1'b0;
  int      exp_count = 0;
  logic    exp_ovf = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at posedge+1; applies one cycle of stimulus and advances the model.
  task automatic cycle(input logic mv, input rvwordT ins, input rvwordT pc, input EpochT ep,
                       input EpochT je, input logic rdy);
    int   cnt;
    logic jmp, acc, ev, dq;
    mem_valid = mv; mem_instr = ins; mem_pc = pc; mem_epoch = ep;
    jump_epoch = je; dec_ready = rdy;
    cnt = sb.size();
    jmp = (je != EPOCH_INVALID);
    acc = mv && (ep == m_acc) && (ep != EPOCH_INVALID) && !jmp;
`ifdef INST_QUEUE_BYPASS_EN
    ev = !jmp && (cnt > 0 || acc);
`else
    ev = !jmp && (cnt > 0);
`endif
    dq = ev && rdy;
    exp_valid = ev;
    exp_count = cnt;
    exp_ovf   = m_ovf;
    if (jmp) begin
      sb.delete();
      m_acc = je;
    end else if (acc) begin
      if (cnt < DEPTH || dq) sb.push_back('{instr: ins, pc: pc, epoch: ep});
      else m_ovf = 1'b1;
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input logic rdy);
    cycle(1'b0, '0, '0, EPOCH_INVALID, EPOCH_INVALID, rdy);
  endtask

  task automatic enq(input rvwordT pc, input EpochT ep, input logic rdy);
    cycle(1'b1, $urandom, pc, ep, EPOCH_INVALID, rdy);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"}, dec_valid, 1'b0);
    chk({tag, "_instr"}, dec_instr, 32'h0);
    chk({tag, "_pc"}, dec_pc, 32'h0);
    chk({tag, "_epoch"}, dec_epoch, EPOCH_INVALID);
    chk({tag, "_afull"}, q_afull, 1'b0);
    chk({tag, "_ovf"}, q_overflow, 1'b0);
  endtask

  task automatic model_reset();
    sb.delete();
    m_acc = EPOCH_RED;
    m_ovf = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst && mon_en) begin
      chk("dec_valid", dec_valid, exp_valid);
      chk("q_afull", q_afull, (exp_count >= DEPTH - SLACK));
      chk("q_overflow", q_overflow, exp_ovf);
      if (!dec_valid) begin
        chk("idle_epoch", dec_epoch, EPOCH_INVALID);
      end else if (sb.size() == 0) begin
        chk("sb_underflow", 1'b1, 1'b0);
      end else begin
        chk("dec_pc", dec_pc, sb[0].pc);
        chk("dec_instr", dec_instr, sb[0].instr);
        chk("dec_epoch", dec_epoch, sb[0].epoch);
        if (dec_ready) void'(sb.pop_front());
      end
    end
  end

  initial begin
    EpochT ep, je;
    int    rdy_pct;
    #1;
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    mon_en = 1'b1;

    // Single response appears one cycle later (or same cycle with bypass).
    enq(32'h0, EPOCH_RED, 1'b1);
    idle(1'b1);

    // Invalid-epoch response is ignored and is not an overflow.
    cycle(1'b1, 32'h1234, 32'h4, EPOCH_INVALID, EPOCH_INVALID, 1'b0);
    idle(1'b0);

    // Fill, overflow on fifth, drain in order.
    for (int i = 0; i < 4; i++) enq(32'(i * 4), EPOCH_RED, 1'b0);
    enq(32'h10, EPOCH_RED, 1'b0);
    idle(1'b0);
    for (int i = 0; i < 5; i++) idle(1'b1);

    // Full queue with simultaneous enqueue and dequeue.
    for (int i = 0; i < 4; i++) enq(32'(i * 4), EPOCH_RED, 1'b0);
    enq(32'h20, EPOCH_RED, 1'b1);
    for (int i = 0; i < 5; i++) idle(1'b1);

    // Redirect flushes queued entries and switches accepted epoch.
    enq(32'h0, EPOCH_RED, 1'b0);
    enq(32'h4, EPOCH_RED, 1'b0);
    cycle(1'b1, 32'hdead, 32'h8, EPOCH_RED, EPOCH_BLUE, 1'b1);
    idle(1'b1);
    enq(32'h8, EPOCH_RED, 1'b0);
    enq(32'h40, EPOCH_BLUE, 1'b0);
    idle(1'b0);
    idle(1'b1);

    // Asynchronous reset between clock edges with three entries queued.
    for (int i = 0; i < 3; i++) enq(32'h80 + 32'(i * 4), EPOCH_BLUE, 1'b0);
    mem_valid = 1'b0; jump_epoch = EPOCH_INVALID; dec_ready = 1'b0;
    #2 rst = 1'b1;
    #1 check_reset_outputs("async_rst");
    @(posedge clk); #1;
    model_reset();
    rst = 1'b0;
    idle(1'b0);

    // Empty queue, response consumed immediately.
    enq(32'h100, EPOCH_RED, 1'b1);
    idle(1'b1);

    // Randomized traffic with varying decode back-pressure.
    rdy_pct = 50;
    for (int n = 0; n < 3000; n++) begin
      if (n % 100 == 0) rdy_pct = $urandom_range(10, 95);
      ep = ($urandom_range(0, 3) != 0) ? m_acc : EpochT'(2'($urandom_range(0, 3)));
      je = ($urandom_range(0, 24) == 0) ? EpochT'(2'($urandom_range(1, 3))) : EPOCH_INVALID;
      cycle(1'($urandom_range(0, 99) < 70), $urandom, {$urandom, 2'b00} & 32'hffff_fffc,
            ep, je, 1'($urandom_range(0, 99) < rdy_pct));
      if (n == 1500) begin
        mem_valid = 1'b0; jump_epoch = EPOCH_INVALID;
        #2 rst = 1'b1;
        #1 check_reset_outputs("rand_rst");
        @(posedge clk); #1;
        model_reset();
        rst = 1'b0;
      end
    end
    for (int i = 0; i < 6; i++) idle(1'b1);
    chk("final_empty", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
